// File: rtl/mux_arb_pkg.sv
// Shared types and helpers for the round-robin mux arbiter.
// The optional grant-lock feature is enabled with the ARB_LOCK_EN macro.
package mux_arb_pkg;

  typedef enum logic {IDLE, HOLD} arb_state_e;

  function automatic int sel_w(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/mux_nx1.sv
// Single-bit N-to-1 multiplexer; S selects which bit of D appears on Y.
module mux_nx1 import mux_arb_pkg::*; #(
  parameter int N = 4
) (
  input  logic [N-1:0]        D,
  input  logic [sel_w(N)-1:0] S,
  output logic                Y
);

  localparam int SW = sel_w(N);

  always_comb begin
    Y = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (S == SW'(i)) Y = D[i];
    end
  end

endmodule

// File: rtl/mux_rr_arbiter_pick.sv
// Combinational round-robin search: first unmasked request at or after ptr, wrapping.
module rr_pick import mux_arb_pkg::*; #(
  parameter int N = 4
) (
  input  logic [N-1:0]        req,
  input  logic [sel_w(N)-1:0] ptr,
  input  logic [N-1:0]        mask,
  output logic                found,
  output logic [sel_w(N)-1:0] idx
);

  localparam int SW = sel_w(N);

  int j;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!found && req[j] && !mask[j]) begin
        found = 1'b1;
        idx   = SW'(j);
      end
    end
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter sharing one Nx1 mux path across N requesters on a valid/ready stream.
// Define ARB_LOCK_EN to add the lock port, which retains a grant across handshakes.
module mux_rr_arbiter import mux_arb_pkg::*; #(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N-1:0]        req,
  input  logic [N*W-1:0]      din,
  output logic [N-1:0]        gnt,
  output logic [sel_w(N)-1:0] out_sel,
  output logic                out_valid,
  output logic [W-1:0]        out_data,
  input  logic                out_ready
`ifdef ARB_LOCK_EN
  ,
  input  logic [N-1:0]        lock
`endif
);

  localparam int SW = sel_w(N);

  arb_state_e    state_q, state_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic [SW-1:0] sel_q, sel_d;
  logic [SW-1:0] ptr_q, ptr_d;

  logic [SW-1:0] pick_ptr, pick_idx, next_ptr;
  logic [N-1:0]  pick_mask, served_oh;
  logic          pick_found, lock_hold;

  function automatic logic [N-1:0] onehot(input logic [SW-1:0] i);
    logic [N-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  rr_pick #(.N(N)) u_pick (
    .req   (req),
    .ptr   (pick_ptr),
    .mask  (pick_mask),
    .found (pick_found),
    .idx   (pick_idx)
  );

`ifdef ARB_LOCK_EN
  assign lock_hold = lock[sel_q];
`else
  assign lock_hold = 1'b0;
`endif

  assign served_oh = onehot(sel_q);
  assign next_ptr  = (sel_q == SW'(N-1)) ? '0 : sel_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    sel_d     = sel_q;
    ptr_d     = ptr_q;
    pick_ptr  = ptr_q;
    pick_mask = '0;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d = HOLD;
          sel_d   = pick_idx;
          gnt_d   = onehot(pick_idx);
        end
      end
      HOLD: begin
        if (out_ready && !lock_hold) begin
          ptr_d    = next_ptr;
          pick_ptr = next_ptr;
          // The served index is skipped only if someone else is waiting.
          if ((req & ~served_oh) != '0) pick_mask = served_oh;
          if (pick_found) begin
            sel_d = pick_idx;
            gnt_d = onehot(pick_idx);
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      sel_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
    end
  end

  assign gnt       = gnt_q;
  assign out_sel   = sel_q;
  assign out_valid = (state_q == HOLD);

  // Bit-sliced datapath: one mux per data bit, all steered by the registered grant index.
  for (genvar b = 0; b < W; b++) begin : g_bit
    logic [N-1:0] col;
    for (genvar i = 0; i < N; i++) begin : g_req
      assign col[i] = din[i*W + b];
    end
    mux_nx1 #(.N(N)) u_mux (
      .D (col),
      .S (sel_q),
      .Y (out_data[b])
    );
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter with a scoreboard of expected delivered words.
module tb_mux_rr_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] din;
  logic [N-1:0]   gnt;
  logic [1:0]     out_sel;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic           out_ready;
  logic [N-1:0]   lock;

  mux_rr_arbiter #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .din       (din),
    .gnt       (gnt),
    .out_sel   (out_sel),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready)
`ifdef ARB_LOCK_EN
    ,
    .lock      (lock)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0] g;
    logic [1:0]   s;
    logic [W-1:0] d;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   words  = 0;
  int   pushed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [N-1:0] g, input logic [1:0] s, input logic [W-1:0] d);
    exp_q.push_back('{g: g, s: s, d: d});
    pushed++;
  endtask

  task automatic set_din(input int i, input logic [W-1:0] v);
    din[i*W +: W] = v;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string name, input logic [1:0] ptr_exp);
    @(negedge clk);
    check({name, "_valid"}, {31'b0, out_valid}, 32'd0);
    check({name, "_gnt"}, {28'b0, gnt}, 32'd0);
    check({name, "_ptr"}, {30'b0, dut.ptr_q}, {30'b0, ptr_exp});
  endtask

  // Monitor: every delivered word is matched against the scoreboard head.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid) begin
      check("hold_onehot", {31'b0, $onehot(gnt)}, 32'd1);
      check("hold_gnt_sel", {31'b0, gnt[out_sel]}, 32'd1);
      if (out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got gnt=%b data=%h with nothing expected", gnt, out_data);
        end else begin
          e = exp_q.pop_front();
          check("word_gnt", {28'b0, gnt}, {28'b0, e.g});
          check("word_sel", {30'b0, out_sel}, {30'b0, e.s});
          check("word_data", {24'b0, out_data}, {24'b0, e.d});
          words++;
        end
      end
    end
  end

  initial begin
    rst = 1'b1; req = '0; din = '0; out_ready = 1'b0; lock = '0;

    // Reset state, then five idle cycles
    step();
    step();
    @(negedge clk);
    check("rst_valid", {31'b0, out_valid}, 32'd0);
    check("rst_gnt", {28'b0, gnt}, 32'd0);
    check("rst_sel", {30'b0, out_sel}, 32'd0);
    step();
    rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("idle_valid", {31'b0, out_valid}, 32'd0);
      check("idle_gnt", {28'b0, gnt}, 32'd0);
      check("idle_sel", {30'b0, out_sel}, 32'd0);
    end

    // Single requester 2
    step();
    set_din(2, 8'hA5); req = 4'b0100; out_ready = 1'b1;
    push(4'b0100, 2'd2, 8'hA5);
    step();
    req = 4'b0000;
    @(negedge clk);
    check("single_gnt", {28'b0, gnt}, 32'b0100);
    step();
    check_idle("single_after", 2'd3);

    // All four requesting, eight back-to-back words starting from ptr=3
    step();
    for (int i = 0; i < N; i++) set_din(i, 8'h10 + 8'(i));
    req = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      int ix;
      ix = (3 + k) % N;
      push(4'(1 << ix), 2'(ix), 8'h10 + 8'(ix));
    end
    repeat (8) step();
    req = 4'b0000;
    step();
    check_idle("all_after", 2'd3);

    // Stall with out_ready low, then release
    step();
    set_din(0, 8'h3C); set_din(1, 8'hC3);
    out_ready = 1'b0; req = 4'b0011;
    push(4'b0001, 2'd0, 8'h3C);
    push(4'b0010, 2'd1, 8'hC3);
    step();
    repeat (4) begin
      @(negedge clk);
      check("stall_gnt", {28'b0, gnt}, 32'b0001);
      check("stall_data", {24'b0, out_data}, 32'h3C);
      check("stall_valid", {31'b0, out_valid}, 32'd1);
    end
    step();
    out_ready = 1'b1;
    step();
    req = 4'b0000;
    @(negedge clk);
    check("stall_next_gnt", {28'b0, gnt}, 32'b0010);
    step();
    check_idle("stall_after", 2'd2);

    // Reset in the middle of a held grant aborts the word
    step();
    out_ready = 1'b0; set_din(1, 8'h5A); req = 4'b0010;
    step();
    @(negedge clk);
    check("pre_rst_gnt", {28'b0, gnt}, 32'b0010);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0; req = 4'b0000;
    check_idle("mid_rst", 2'd0);
    step();
    set_din(3, 8'h77); req = 4'b1010; out_ready = 1'b1;
    push(4'b0010, 2'd1, 8'h5A);
    push(4'b1000, 2'd3, 8'h77);
    step();
    req = 4'b1000;
    @(negedge clk);
    check("post_rst_gnt", {28'b0, gnt}, 32'b0010);
    step();
    req = 4'b0000;
    step();
    check_idle("post_rst_after", 2'd0);

`ifdef ARB_LOCK_EN
    // Locked grant survives three handshakes, then releases
    step();
    set_din(0, 8'hE1); set_din(1, 8'h1E);
    req = 4'b0011; lock = 4'b0001;
    repeat (4) push(4'b0001, 2'd0, 8'hE1);
    push(4'b0010, 2'd1, 8'h1E);
    step();
    step();
    step();
    step();
    lock = 4'b0000;
    step();
    req = 4'b0000;
    @(negedge clk);
    check("lock_release_gnt", {28'b0, gnt}, 32'b0010);
    step();
    check_idle("lock_after", 2'd2);
`endif

    repeat (3) step();
    check("queue_empty", exp_q.size(), 32'd0);
    check("word_count", words, pushed);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
